// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: state, opcode and func codes,
// and the bundled control-output record.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_BGZ   = 4'd2;
    localparam logic [3:0] OP_BLZ   = 4'd3;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    // Width of the memory wait counter (supports MEM_LAT up to 15).
    localparam int WAIT_W = 4;

    typedef struct packed {
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       pc_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_op;
        logic       save_alu_out;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       wwd;
        logic       halt;
        logic       new_inst;
    } ctrl_t;

    function automatic logic is_branch(input logic [3:0] op);
        return op inside {OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ};
    endfunction

    // Func-coded instructions only exist under the R-type opcode.
    function automatic logic is_func(input logic [3:0] op, input logic [5:0] fn,
                                     input logic [5:0] code);
        return (op == OP_RTYPE) && (fn == code);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_wait.sv
// Memory wait counter: clears whenever the controller changes state, counts
// the cycles spent in a memory state, and signals access completion.
module mem_wait_ctr
    import multicycle_ctrl_pkg::*;
#(
    parameter int LAT       = 4,
    parameter int USE_READY = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic ready,
    output logic done
);

    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(LAT - 1);

    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              lat_hit;

    assign lat_hit = (cnt_q == LAST);
    assign done    = (USE_READY != 0) ? ready : lat_hit;

    // Next count: clear on reset or state entry, otherwise saturate at LAT-1.
    always_comb begin
        cnt_d = cnt_q;
        if (!lat_hit)
            cnt_d = cnt_q + WAIT_W'(1);
        if (!reset_n || start)
            cnt_d = '0;
    end

    // Count register.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU controller: IF/ID/EX/MEM/WB/HALT sequencer with fully
// combinational control decode and a retired-instruction counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_LAT   = 4,
    parameter int USE_READY = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       opcode,
    input  logic [5:0]       func_code,
    input  logic             bcond,
    input  logic             mem_ready,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             pc_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             alu_op,
    output logic             save_alu_out,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             wwd,
    output logic             halt,
    output logic             new_inst,
    output logic [CNT_W-1:0] inst_count
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   inst_count_q, inst_count_d;
    logic               acc_done;
    logic               hlt_entry;
    ctrl_t              ctl;

    logic is_jpr, is_jrl, is_wwd, is_hlt;
    assign is_jpr = is_func(opcode, func_code, FN_JPR);
    assign is_jrl = is_func(opcode, func_code, FN_JRL);
    assign is_wwd = is_func(opcode, func_code, FN_WWD);
    assign is_hlt = is_func(opcode, func_code, FN_HLT);

    mem_wait_ctr #(.LAT(MEM_LAT), .USE_READY(USE_READY)) u_wait (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (state_d != state_q),
        .ready   (mem_ready),
        .done    (acc_done)
    );

    // State and counter registers; reset is folded into the _d logic.
    always_ff @(posedge clk) begin
        state_q      <= state_d;
        inst_count_q <= inst_count_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:   if (acc_done) state_d = S_ID;
            S_ID: begin
                if (opcode == OP_JMP || is_wwd) state_d = S_IF;
                else if (opcode == OP_JAL)      state_d = S_WB;
                else if (is_hlt)                state_d = S_HALT;
                else                            state_d = S_EX;
            end
            S_EX: begin
                if (is_branch(opcode) || is_jpr)                  state_d = S_IF;
                else if (opcode == OP_LWD || opcode == OP_SWD)    state_d = S_MEM;
                else                                              state_d = S_WB;
            end
            S_MEM:  if (acc_done) state_d = (opcode == OP_LWD) ? S_WB : S_IF;
            S_WB:   state_d = S_IF;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
        if (!reset_n)
            state_d = S_IF;
    end

    // Control outputs decoded from state, opcode, func_code (and bcond in EX).
    always_comb begin
        ctl = '0;
        case (state_q)
            S_IF: begin
                ctl.mem_read = 1'b1;
                ctl.ir_write = acc_done;
            end
            S_ID: begin
                ctl.alu_src_b    = 2'd1;
                ctl.save_alu_out = 1'b1;
                if (opcode == OP_JMP) begin
                    ctl.pc_write = 1'b1;
                    ctl.pc_src   = 2'd2;
                    ctl.new_inst = 1'b1;
                end else if (is_wwd) begin
                    ctl.wwd      = 1'b1;
                    ctl.pc_write = 1'b1;
                    ctl.new_inst = 1'b1;
                end
            end
            S_EX: begin
                ctl.alu_src_a    = 1'b1;
                ctl.alu_op       = 1'b1;
                ctl.save_alu_out = 1'b1;
                if (opcode == OP_LHI)
                    ctl.alu_src_b = 2'd3;
                else if (opcode inside {OP_ADI, OP_ORI, OP_LWD, OP_SWD})
                    ctl.alu_src_b = 2'd2;
                if (is_branch(opcode)) begin
                    ctl.pc_write = 1'b1;
                    ctl.pc_src   = bcond ? 2'd1 : 2'd0;
                    ctl.new_inst = 1'b1;
                end else if (is_jpr) begin
                    ctl.pc_write = 1'b1;
                    ctl.pc_src   = 2'd1;
                    ctl.new_inst = 1'b1;
                end
            end
            S_MEM: begin
                ctl.i_or_d    = 1'b1;
                ctl.mem_read  = (opcode == OP_LWD);
                ctl.mem_write = (opcode == OP_SWD);
                if (acc_done && opcode == OP_SWD) begin
                    ctl.pc_write = 1'b1;
                    ctl.new_inst = 1'b1;
                end
            end
            S_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.pc_write   = 1'b1;
                ctl.new_inst   = 1'b1;
                ctl.mem_to_reg = (opcode == OP_LWD);
                ctl.pc_to_reg  = (opcode == OP_JAL) || is_jrl;
                ctl.pc_src     = (opcode == OP_JAL) ? 2'd2 : (is_jrl ? 2'd1 : 2'd0);
            end
            S_HALT: ctl.halt = 1'b1;
            default: ctl = '0;
        endcase
    end

    // HLT retires on its way into HALT even though new_inst stays low there.
    assign hlt_entry = (state_q == S_ID) && is_hlt;

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_comb begin
        inst_count_d = inst_count_q;
        if (ctl.new_inst || hlt_entry)
            inst_count_d = inst_count_q + CNT_W'(1);
        if (!reset_n)
            inst_count_d = '0;
    end

    assign i_or_d       = ctl.i_or_d;
    assign mem_read     = ctl.mem_read;
    assign mem_write    = ctl.mem_write;
    assign ir_write     = ctl.ir_write;
    assign mem_to_reg   = ctl.mem_to_reg;
    assign reg_write    = ctl.reg_write;
    assign pc_to_reg    = ctl.pc_to_reg;
    assign alu_src_a    = ctl.alu_src_a;
    assign alu_src_b    = ctl.alu_src_b;
    assign alu_op       = ctl.alu_op;
    assign save_alu_out = ctl.save_alu_out;
    assign pc_write     = ctl.pc_write;
    assign pc_src       = ctl.pc_src;
    assign wwd          = ctl.wwd;
    assign halt         = ctl.halt;
    assign new_inst     = ctl.new_inst;
    assign inst_count   = inst_count_q;

endmodule
